// File: rtl/pio_instr_issue_ctrl.sv
// pio_instr_issue_ctrl: captures HPS instruction words from the PIO bridge into a
// small FIFO, issues them one at a time to the coprocessor over valid/ready,
// waits for completion (with timeout) and reports sticky status back via PIO.
module pio_instr_issue_ctrl #(
    parameter int INSTR_W = 29,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [1:0]         pio_control,
    input  logic [INSTR_W-1:0] pio_instruction,
    output logic [3:0]         pio_status,
    output logic [INSTR_W-1:0] cop_instr,
    output logic               cop_valid,
    input  logic               cop_ready,
    input  logic               cop_done,
    input  logic               cop_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FAULT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_ctl0_q;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [TMR_W-1:0]   r_timer;
    logic [INSTR_W-1:0] r_cop_instr;
    logic               r_cop_valid;
    logic               r_done;
    logic               r_err;
    logic               r_full;
    logic               r_busy;

    logic               w_clr;
    logic               w_enq;
    logic               w_full;
    logic               w_push;
    logic               w_overflow;
    logic               w_pop;
    logic               w_cpl_ok;
    logic               w_cpl_err;
    logic               w_timeout;
    logic               w_valid_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    // PIOs share our clock, so a plain register is enough for edge detection.
    assign w_clr      = pio_control[1];
    assign w_enq      = pio_control[0] & ~r_ctl0_q;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_push     = w_enq & ~w_full & ~w_clr;
    assign w_overflow = w_enq &  w_full & ~w_clr;

    // FSM next state and issue-side next values; soft clear overrides everything.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_valid_nxt = r_cop_valid;
        w_instr_nxt = r_cop_instr;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_cpl_ok    = 1'b0;
        w_cpl_err   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_instr_nxt = r_mem[r_rd_ptr];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cop_ready) begin
                    w_pop       = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cop_done) begin
                    if (cop_error) begin
                        w_cpl_err   = 1'b1;
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_cpl_ok    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_timer == TMR_W'(TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FAULT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_clr) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_timer_nxt = '0;
            w_pop       = 1'b0;
        end
    end

    // FIFO occupancy and sticky flag next values.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
        w_done_nxt = r_done;
        if (w_cpl_ok || w_cpl_err) begin
            w_done_nxt = 1'b1;
        end
        // An accepted enqueue wins over a same-cycle completion.
        if (w_push) begin
            w_done_nxt = 1'b0;
        end
        w_err_nxt = r_err | w_overflow | w_cpl_err | w_timeout;
        if (w_clr) begin
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, pointers and registered status.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ctl0_q    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_cop_instr <= '0;
            r_cop_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_full      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ctl0_q    <= pio_control[0];
            r_count     <= w_count_nxt;
            r_timer     <= w_timer_nxt;
            r_cop_instr <= w_instr_nxt;
            r_cop_valid <= w_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_full      <= (w_count_nxt == CNT_W'(DEPTH));
            r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            if (w_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_clk) begin
        // NOTE: storage is not reset; the count and pointers alone decide what is valid.
        if (w_push) begin
            r_mem[r_wr_ptr] <= pio_instruction;
        end
    end

    assign pio_status = {r_busy, r_full, r_err, r_done};
    assign cop_instr  = r_cop_instr;
    assign cop_valid  = r_cop_valid;

endmodule

// File: tb/tb_pio_instr_issue_ctrl.sv
// Directed self-checking bench for pio_instr_issue_ctrl (DEPTH=4, TIMEOUT=16).
module tb_pio_instr_issue_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  pio_control;
    logic [28:0] pio_instruction;
    logic [3:0]  pio_status;
    logic [28:0] cop_instr;
    logic        cop_valid;
    logic        cop_ready;
    logic        cop_done;
    logic        cop_error;

    int n_checks = 0;
    int n_errors = 0;

    pio_instr_issue_ctrl #(
        .INSTR_W (29),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) u_dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .pio_control     (pio_control),
        .pio_instruction (pio_instruction),
        .pio_status      (pio_status),
        .cop_instr       (cop_instr),
        .cop_valid       (cop_valid),
        .cop_ready       (cop_ready),
        .cop_done        (cop_done),
        .cop_error       (cop_error)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Rising edge on control[0] with the word held; push lands on the first edge.
    task automatic enq(input logic [28:0] word);
        pio_instruction = word;
        pio_control[0]  = 1'b1;
        tick();
        pio_control[0]  = 1'b0;
        tick();
    endtask

    task automatic soft_clear();
        pio_control[1] = 1'b1;
        tick();
        pio_control[1] = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!cop_valid && n < 50) begin
            tick();
            n++;
        end
        check("valid_seen", {31'b0, cop_valid}, 32'd1);
    endtask

    // Accept the presented word, then complete it lat cycles after transfer.
    task automatic serve(input logic [28:0] exp, input int lat, input bit err);
        wait_valid();
        check("issue_instr", {3'b0, cop_instr}, {3'b0, exp});
        cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        check("valid_drop", {31'b0, cop_valid}, 32'd0);
        repeat (lat - 1) tick();
        cop_done  = 1'b1;
        cop_error = err;
        tick();
        cop_done  = 1'b0;
        cop_error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset_n   = 1'b0;
        pio_control     = 2'b00;
        pio_instruction = '0;
        cop_ready       = 1'b0;
        cop_done        = 1'b0;
        cop_error       = 1'b0;
        tick();
        tick();
        check("rst_status", {28'b0, pio_status}, 32'h0);
        check("rst_valid", {31'b0, cop_valid}, 32'd0);
        check("rst_instr", {3'b0, cop_instr}, 32'h0);
        reset_reset_n = 1'b1;
        tick();

        // Single instruction with ready held high in advance.
        cop_ready       = 1'b1;
        pio_instruction = 29'h0ABCDEF;
        pio_control[0]  = 1'b1;
        tick();
        check("t1_busy_on_push", {28'b0, pio_status}, 32'b1000);
        pio_control[0] = 1'b0;
        tick();
        check("t1_valid", {31'b0, cop_valid}, 32'd1);
        check("t1_instr", {3'b0, cop_instr}, 32'h0ABCDEF);
        tick();
        check("t1_xfer_first_cycle", {31'b0, cop_valid}, 32'd0);
        cop_ready = 1'b0;
        repeat (4) tick();
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        check("t1_status_done", {28'b0, pio_status}, 32'b0001);
        repeat (3) tick();
        check("t1_single_xfer", {31'b0, cop_valid}, 32'd0);

        // Fill, overflow, then drain in order.
        enq(29'h0111_1111);
        check("t2_held_instr", {3'b0, cop_instr}, 32'h0111_1111);
        enq(29'h0222_2222);
        enq(29'h0333_3333);
        enq(29'h0444_4444);
        check("t2_full", {28'b0, pio_status}, 32'b1100);
        enq(29'h0555_5555);
        check("t2_overflow", {28'b0, pio_status}, 32'b1110);
        check("t2_still_holding", {31'b0, cop_valid}, 32'd1);
        serve(29'h0111_1111, 2, 1'b0);
        serve(29'h0222_2222, 2, 1'b0);
        serve(29'h0333_3333, 2, 1'b0);
        serve(29'h0444_4444, 2, 1'b0);
        repeat (3) tick();
        check("t2_fifth_dropped", {31'b0, cop_valid}, 32'd0);
        check("t2_drained_status", {28'b0, pio_status}, 32'b0011);
        soft_clear();
        check("t2_clear", {28'b0, pio_status}, 32'h0);

        // Error completion enters FAULT and stops issuing.
        enq(29'h0A0A_0A0A);
        enq(29'h0B0B_0B0B);
        serve(29'h0A0A_0A0A, 2, 1'b1);
        check("t3_fault_status", {28'b0, pio_status}, 32'b1011);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_no_issue", {31'b0, cop_valid}, 32'd0);
        end
        soft_clear();
        check("t3_clear", {28'b0, pio_status}, 32'h0);
        tick();
        check("t3_idle_after_clear", {31'b0, cop_valid}, 32'd0);

        // Timeout: error appears exactly 17 edges after the transfer.
        enq(29'h0C0C_0C0C);
        wait_valid();
        cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        repeat (16) tick();
        check("t4_no_err_yet", {31'b0, pio_status[1]}, 32'd0);
        tick();
        check("t4_timeout_status", {28'b0, pio_status}, 32'b1010);
        soft_clear();
        check("t4_clear", {28'b0, pio_status}, 32'h0);

        // Push and pop on the same edge keep the count.
        enq(29'h0D00_0001);
        enq(29'h0D00_0002);
        enq(29'h0D00_0003);
        pio_instruction = 29'h0D00_0004;
        pio_control[0]  = 1'b1;
        cop_ready       = 1'b1;
        tick();
        pio_control[0]  = 1'b0;
        cop_ready       = 1'b0;
        check("t5a_count_kept", {28'b0, pio_status}, 32'b1000);
        tick();
        enq(29'h0D00_0005);
        check("t5a_full_after", {28'b0, pio_status}, 32'b1100);
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        check("t5a_done", {28'b0, pio_status}, 32'b1101);
        serve(29'h0D00_0002, 1, 1'b0);
        serve(29'h0D00_0003, 1, 1'b0);
        serve(29'h0D00_0004, 1, 1'b0);
        serve(29'h0D00_0005, 1, 1'b0);
        check("t5a_end", {28'b0, pio_status}, 32'b0001);

        // Enqueue on the completion edge leaves done at 0.
        enq(29'h0E0E_0E0E);
        wait_valid();
        cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        tick();
        cop_done        = 1'b1;
        pio_instruction = 29'h0F0F_0F0F;
        pio_control[0]  = 1'b1;
        tick();
        cop_done       = 1'b0;
        pio_control[0] = 1'b0;
        check("t5b_done_cleared", {28'b0, pio_status}, 32'b1000);
        tick();
        serve(29'h0F0F_0F0F, 1, 1'b0);
        check("t5b_end", {28'b0, pio_status}, 32'b0001);

        // Enqueue together with soft clear is discarded.
        pio_instruction = 29'h0123_4567;
        pio_control     = 2'b11;
        tick();
        pio_control     = 2'b00;
        check("t5c_status", {28'b0, pio_status}, 32'h0);
        repeat (3) tick();
        check("t5c_nothing_issued", {31'b0, cop_valid}, 32'd0);

        // Asynchronous reset in WAIT, then a clean restart.
        enq(29'h0765_4321);
        wait_valid();
        cop_ready = 1'b1;
        tick();
        cop_ready = 1'b0;
        tick();
        #2 reset_reset_n = 1'b0;
        #1;
        check("t6_async_status", {28'b0, pio_status}, 32'h0);
        check("t6_async_valid", {31'b0, cop_valid}, 32'd0);
        check("t6_async_instr", {3'b0, cop_instr}, 32'h0);
        tick();
        reset_reset_n = 1'b1;
        tick();
        check("t6_post_reset", {28'b0, pio_status}, 32'h0);
        enq(29'h0ACE_0ACE);
        serve(29'h0ACE_0ACE, 3, 1'b0);
        check("t6_restart", {28'b0, pio_status}, 32'b0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pio_instr_issue_ctrl.md
# pio_instr_issue_ctrl

Sequences coprocessor instructions written by the HPS through the lightweight PIO bridge. It sits in the FPGA fabric between the `soc_system` PIO exports (2-bit control out, 29-bit instruction out, 4-bit status in) and the graphics/arithmetic coprocessor. It captures each instruction on a control strobe into a small FIFO and issues entries one at a time over a valid/ready handshake. It waits for completion with a timeout and reports sticky status back to the HPS.

## Interface
Parameters:
- `INSTR_W`, 29: instruction width; must match the instruction PIO.
- `DEPTH`, 4: FIFO depth; a power of two, at least 2.
- `TIMEOUT`, 4095: maximum cycles spent in WAIT before a fault; at least 1.

Ports:
- `clk_clk`, in, 1: system clock; same clock as the PIOs.
- `reset_reset_n`, in, 1: reset, asynchronous assert, active-low.
- `pio_control`, in, 2: [0] enqueue strobe, acting on its rising edge; [1] soft clear, level-sensitive.
- `pio_instruction`, in, INSTR_W: instruction word; stable while [0] rises.
- `pio_status`, out, 4: [0] done (sticky), [1] error (sticky), [2] FIFO full, [3] busy.
- `cop_instr`, out, INSTR_W: instruction presented to the coprocessor.
- `cop_valid`, out, 1: `cop_instr` is valid.
- `cop_ready`, in, 1: coprocessor accepts the instruction.
- `cop_done`, in, 1: single-cycle completion pulse.
- `cop_error`, in, 1: qualifies `cop_done`; the instruction failed.

## Operation
- Edge detect: `ctl0_q` registers `pio_control[0]`. An enqueue is `pio_control[0] & ~ctl0_q`. No synchronizer is used because the PIOs are on the same clock.
- FIFO: circular buffer with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a log2(DEPTH)+1-bit count.
  - Enqueue while not full: write `pio_instruction`, count +1.
  - Enqueue while full: word is dropped, error is set, count is unchanged.
  - Push and pop in the same cycle: both happen, count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, FAULT.
  - IDLE: if count≠0, load `cop_instr` from the FIFO head, assert `cop_valid`, go to ISSUE.
  - ISSUE: hold `cop_valid`=1 and `cop_instr` stable until `cop_ready`=1. On that cycle, pop the FIFO, drop `cop_valid`, clear the timer, go to WAIT.
  - WAIT: the timer increments every cycle.
    - `cop_done`=1 and `cop_error`=0: set done, go to IDLE.
    - `cop_done`=1 and `cop_error`=1: set done and error, go to FAULT.
    - Timer reaches TIMEOUT with no done: set error, go to FAULT.
  - FAULT: issue nothing; the FIFO keeps accepting enqueues. Only soft clear leaves this state.
- Soft clear (`pio_control[1]`=1): go to IDLE, flush the FIFO (pointers and count to 0), clear done and error, drop `cop_valid`.
  - It overrides everything, including a simultaneous enqueue, which is discarded.
  - While held high, it keeps the block in its cleared state.
- Done flag: cleared by an accepted enqueue. If completion and an accepted enqueue occur in the same cycle, done ends at 0.
- Status bits: full = (count==DEPTH); busy = (state≠IDLE) | (count≠0). All `pio_status` bits are registered.
- Stray `cop_done` outside WAIT is ignored.

## Timing
- Reset values: `pio_status`=0, `cop_valid`=0, `cop_instr`=0, state IDLE, FIFO empty, `ctl0_q`=0, timer=0.
- Enqueue to issue: enqueue sampled at edge k; FIFO written at edge k; `cop_valid`=1 after edge k+1 when idle and the FIFO was empty.
- Status lag: `pio_status` reflects an event one edge after it is sampled. Full and busy update with the push.
- Handshake: transfer happens on an edge where `cop_valid` and `cop_ready` are both 1. `cop_ready` may be high in advance, giving a transfer on the first valid cycle.
- Back-to-back issue: done at edge m leads to IDLE; `cop_valid` rises again after edge m+1. Throughput is at most one instruction per 3 cycles plus coprocessor latency.
- Timeout: fault occurs TIMEOUT cycles after entering WAIT; `pio_status[1]` is visible one edge later.
- Reset asserted mid-ISSUE or mid-WAIT: `cop_valid` drops immediately (asynchronously); the in-flight instruction is abandoned.

## Test plan
- Single instruction: enqueue 0x0ABCDEF with `cop_ready`=1 and `cop_done` 5 cycles after transfer. Expect `cop_instr`=0x0ABCDEF, one transfer, then `pio_status`=4'b0001.
- Full and overflow: hold `cop_ready`=0 and enqueue 5 words with DEPTH=4.
  - Expect full after the 4th, error=1 after the 5th, and the 5th word never issued.
  - Then release ready and complete all; expect the first 4 words issued in FIFO order.
- Error completion: `cop_done`=`cop_error`=1. Expect FAULT, status=4'b1011 when words are queued, and no further `cop_valid`. Soft clear gives status=0.
- Timeout: TIMEOUT=16 and no `cop_done`. Expect error exactly 17 edges after the transfer, then FAULT.
- Simultaneous events:
  - Enqueue on the same edge as a pop: count unchanged.
  - Enqueue on the same edge as completion: done=0.
  - Enqueue together with soft clear: FIFO empty.
- Reset mid-WAIT: assert `reset_reset_n`=0 asynchronously. Expect all outputs 0 before the next edge and a clean restart afterwards.
